out_fifo: RTL

OUT_FIFO -- requirements
Module: out_fifo

---
 rtl/out_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/out_fifo.sv
// out_fifo: circular-buffer output queue between an upstream arbiter and a
// downstream consumer. Registered read data with one-cycle latency, no
// fall-through, registered status flags and sticky overflow/underflow flags.
//
// Ports:
//   clk          clock, all registers sample on the rising edge
//   reset        asynchronous active-high reset
//   push         write request
//   data_in      word written on an accepted push ({dest[1:0], payload[3:0]})
//   pop          read request
//   data_out     registered read data, holds between pops
//   valid_out    high for the one cycle data_out carries a newly popped word
//   empty        occupancy == 0
//   almost_full  occupancy >= AF_THRESH (back-pressure to the arbiter)
//   full         occupancy == DEPTH
//   count        current occupancy
//   err_ovf      sticky: push while full without an accepted pop
//   err_udf      sticky: pop while empty
module out_fifo #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     pop,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_ovf,
  output logic                     err_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] PTR_INC = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic [CW-1:0]     count_nxt;

  // A push into a full queue is still accepted when a pop frees a slot on
  // the same edge; the read below sees the old entry, so the oldest word
  // leaves even though both pointers address the same slot.
  always_comb begin
    pop_ok    = pop && !empty;
    push_ok   = push && (!full || pop_ok);
    count_nxt = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      full        <= 1'b0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      err_ovf     <= 1'b0;
      err_udf     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_INC;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + PTR_INC;
        data_out <= mem[rd_ptr];
      end
      valid_out   <= pop_ok;
      count       <= count_nxt;
      // Flags come from the next-state count so they line up with count.
      empty       <= (count_nxt == '0);
      almost_full <= (count_nxt >= AF_C);
      full        <= (count_nxt == FULL_C);
      if (push && !push_ok) err_ovf <= 1'b1;
      if (pop && !pop_ok)   err_udf <= 1'b1;
    end
  end

endmodule
